muxn_cxu: RTL

MUXN_CXU -- requirements
Module: muxn_cxu

---
 rtl/muxn_cxu.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/muxn_cxu.sv
// Purpose : routes upstream CXU requests to one of N_CXUS targets and returns the
//           responses upstream strictly in the order the requests were accepted.
// Ports   : clk/rst/clk_en; upstream req_* / resp_*; per-target t_req_* / t_resp_*.
// Latency : zero added cycles on both paths; request and response are combinational.
// Backpr. : req_ready drops when the order FIFO is full or the selected target stalls;
//           only the target owning the oldest outstanding tag sees resp_ready.

package muxn_cxu_pkg;
    typedef logic [9:0] cfid_t;

    localparam int CXU_STATUS_W = 2;
    typedef logic [CXU_STATUS_W-1:0] cxu_status_t;

    localparam cxu_status_t CXU_STATUS_OK    = 2'd0;
    localparam cxu_status_t CXU_STATUS_ERROR = 2'd2;
endpackage

// Purpose : generic synchronous FIFO with occupancy counter, used here for order tags.
// Ports   : push/push_dat write side, pop/head_dat read side (head is show-ahead),
//           empty/full status. Push is ignored when full, pop is ignored when empty.
// Latency : a pushed word is visible at head_dat the cycle after the push edge.
module muxn_cxu_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the natural pointer roll-over is the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the counter covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

// Purpose : one-to-N CXU request demux with in-order response mux.
// Latency : 0 cycles request path, 0 cycles response path (no register stages).
// Backpr. : request stalls on full order FIFO or busy target; response stalls hold the head.
module muxn_cxu
    import muxn_cxu_pkg::*;
#(
    parameter int  N_CXUS      = 4,
    parameter int  N_STATES    = 1,
    parameter int  FUNC_ID_W   = $bits(cfid_t),
    parameter int  DATA_W      = 32,
    parameter int  ORDER_DEPTH = 8,
    localparam int CXU_ID_W    = ($clog2(N_CXUS) > 1) ? $clog2(N_CXUS) : 1,
    localparam int STATE_W     = ($clog2(N_STATES) > 1) ? $clog2(N_STATES) : 1,
    localparam int TAG_W       = $clog2(N_CXUS + 1),
    localparam int STATUS_W    = $bits(cxu_status_t)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clk_en,
    // upstream request
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [CXU_ID_W-1:0]                req_cxu,
    input  logic [STATE_W-1:0]                 req_state,
    input  logic [FUNC_ID_W-1:0]               req_func,
    input  logic [DATA_W-1:0]                  req_data0,
    input  logic [DATA_W-1:0]                  req_data1,
    // upstream response
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [STATUS_W-1:0]                resp_status,
    output logic [DATA_W-1:0]                  resp_data,
    // per-target request
    output logic [N_CXUS-1:0]                  t_req_valid,
    input  logic [N_CXUS-1:0]                  t_req_ready,
    output logic [STATE_W-1:0]                 t_req_state,
    output logic [FUNC_ID_W-1:0]               t_req_func,
    output logic [DATA_W-1:0]                  t_req_data0,
    output logic [DATA_W-1:0]                  t_req_data1,
    // per-target response
    input  logic [N_CXUS-1:0]                  t_resp_valid,
    output logic [N_CXUS-1:0]                  t_resp_ready,
    input  logic [N_CXUS-1:0][STATUS_W-1:0]    t_resp_status,
    input  logic [N_CXUS-1:0][DATA_W-1:0]      t_resp_data
);
    localparam int                PAD_N    = 1 << CXU_ID_W;
    localparam logic [TAG_W-1:0]  ERR_TAG  = TAG_W'(N_CXUS);
    localparam logic [CXU_ID_W:0] N_CXUS_X = (CXU_ID_W + 1)'(N_CXUS);

    logic             req_err;
    logic [TAG_W-1:0] req_tag;
    logic [PAD_N-1:0] t_req_ready_pad;
    logic             tgt_ready;
    logic             order_full;
    logic             order_empty;
    logic [TAG_W-1:0] head_tag;
    logic             head_err;
    logic             push;
    logic             pop;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------

    // An out-of-range target id becomes the error tag; it never reaches a target.
    assign req_err = ({1'b0, req_cxu} >= N_CXUS_X);
    assign req_tag = req_err ? ERR_TAG : TAG_W'(req_cxu);

    // Padding to a power of two lets req_cxu index safely even when out of range.
    always_comb begin
        t_req_ready_pad                = '0;
        t_req_ready_pad[N_CXUS-1:0]    = t_req_ready;
    end

    assign tgt_ready = req_err || t_req_ready_pad[req_cxu];

    // Gated by rst so nothing is offered upstream or downstream while in reset.
    assign req_ready = !rst && !order_full && tgt_ready;

    always_comb begin
        t_req_valid = '0;
        for (int i = 0; i < N_CXUS; i++) begin
            t_req_valid[i] = req_valid && !rst && !order_full && (req_tag == TAG_W'(i));
        end
    end

    // Payload is broadcast; only the target with t_req_valid set consumes it.
    assign t_req_state = req_state;
    assign t_req_func  = req_func;
    assign t_req_data0 = req_data0;
    assign t_req_data1 = req_data1;

    assign push = req_valid && req_ready && clk_en;

    // ------------------------------------------------------------------
    // Order tracking: one tag per accepted request, oldest at the head.
    // A full FIFO refuses the push even when a pop happens in the same
    // cycle, which keeps req_ready independent of resp_ready.
    // ------------------------------------------------------------------
    muxn_cxu_fifo #(
        .W     (TAG_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (req_tag),
        .pop      (pop),
        .head_dat (head_tag),
        .empty    (order_empty),
        .full     (order_full)
    );

    // ------------------------------------------------------------------
    // Response side: the head tag picks which target may talk upstream.
    // Younger targets that are already done simply wait with t_resp_ready low.
    // ------------------------------------------------------------------
    assign head_err = (head_tag == ERR_TAG);

    always_comb begin
        resp_valid   = 1'b0;
        resp_status  = '0;
        resp_data    = '0;
        t_resp_ready = '0;
        if (!order_empty) begin
            if (head_err) begin
                // Synthesised error reply; no target is involved.
                resp_valid  = 1'b1;
                resp_status = CXU_STATUS_ERROR;
            end else begin
                for (int i = 0; i < N_CXUS; i++) begin
                    if (head_tag == TAG_W'(i)) begin
                        resp_valid      = t_resp_valid[i];
                        resp_status     = t_resp_status[i];
                        resp_data       = t_resp_data[i];
                        t_resp_ready[i] = resp_ready;
                    end
                end
            end
        end
    end

    assign pop = resp_valid && resp_ready && clk_en;
endmodule
